// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial WIDTH-bit adder around one full_adder.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder (
   input  logic p,
   input  logic q,
   input  logic r,
   output logic sum,
   output logic carry
);
   assign sum   = p ^ q ^ r;
   assign carry = (p & q) | (r & (p ^ q));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] a_sr, b_sr, r_sr;
   logic [CW-1:0] cnt;
   logic carry_q, fa_sum, fa_carry, take, last;
   full_adder fa (
      .p(a_sr[0]),
      .q(b_sr[0]),
      .r(carry_q),
      .sum(fa_sum),
      .carry(fa_carry)
   );
   assign take = start && state != RUN;
   assign last = cnt == CW'(WIDTH - 1);
   assign busy = state == RUN;
   assign done = state == DONE;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         r_sr    <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else if (take) begin
         a_sr    <= a;
         b_sr    <= b;
         carry_q <= cin;
         cnt     <= '0;
      end else if (state == RUN) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         r_sr    <= {fa_sum, r_sr[WIDTH-1:1]};
         carry_q <= fa_carry;
         cnt     <= cnt + 1'b1;
         if (last) begin
            sum  <= {fa_sum, r_sr[WIDTH-1:1]};
            cout <= fa_carry;
         end
      end
   end
`ifdef SERIAL_ADDER_OVF_EN
   // carry_q on the last RUN cycle is the carry into the MSB
   always_ff @(posedge clk) begin
      if (rst) ovf <= 1'b0;
      else if (state == RUN && last) ovf <= carry_q ^ fa_carry;
   end
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against an arithmetic model.
module tb_serial_adder;
   localparam int W = 8;
   logic clk = 0, rst = 1, start = 0, cin = 0;
   logic [W-1:0] a = '0, b = '0;
   logic busy, done, cout;
   logic [W-1:0] sum;
   logic ovf_obs;
   int checks = 0, errors = 0;
   logic [W-1:0] hold_sum = '0;
   logic hold_cout = 0;
   always #5 clk = ~clk;
`ifdef SERIAL_ADDER_OVF_EN
   logic ovf;
   assign ovf_obs = ovf;
`else
   assign ovf_obs = 1'b0;
`endif
   serial_adder #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .a(a),
      .b(b),
      .cin(cin),
      .busy(busy),
      .done(done),
      .sum(sum),
      .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf(ovf)
`endif
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // One addition from the cycle start is driven to the done cycle; glitch>=0 pulses a stray start mid-run
   task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input int glitch);
      int n, busy_n;
      logic [W:0] e;
      logic eo;
      e  = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
      eo = (ta[W-1] == tb_[W-1]) && (e[W-1] != ta[W-1]);
      a = ta; b = tb_; cin = tc; start = 1;
      step();
      start = 0;
      chk("busy_after_start", busy, 1);
      n = 0;
      busy_n = 0;
      while (!done && n < 3 * W) begin
         if (busy) busy_n++;
         if (n == W / 2) begin
            chk("held_sum", sum, hold_sum);
            chk("held_cout", cout, hold_cout);
         end
         if (n == glitch) begin
            start = 1; a = '1; b = '1; cin = 1;
         end else start = 0;
         step();
         n++;
      end
      start = 0;
      chk("latency", n, W);
      chk("busy_cycles", busy_n, W);
      chk("done", done, 1);
      chk("busy_at_done", busy, 0);
      chk("sum", sum, e[W-1:0]);
      chk("cout", cout, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", ovf_obs, eo);
`endif
      hold_sum = e[W-1:0];
      hold_cout = e[W];
   endtask
   initial begin
      step();
      step();
      rst = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf_obs, 0);
      step();
      op(8'h0F, 8'h01, 0, -1);
      step();
      chk("done_pulse_1cyc", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_hold_sum", sum, hold_sum);
      op(8'hFF, 8'h01, 0, -1);
      step();
      op(8'h00, 8'h00, 1, -1);
      step();
      op(8'h7F, 8'h01, 0, -1);
      step();
      op(8'h80, 8'h80, 0, -1);
      step();
      op(8'h12, 8'h34, 0, 3);
      op(8'hAA, 8'h55, 0, -1);
      op(8'hFF, 8'hFF, 1, -1);
      step();
      a = 8'h21; b = 8'h43; cin = 0; start = 1;
      step();
      start = 0;
      repeat (3) step();
      rst = 1;
      step();
      rst = 0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      chk("abort_ovf", ovf_obs, 0);
      begin
         int seen = 0;
         repeat (2 * W) begin
            step();
            if (done || busy) seen++;
         end
         chk("no_done_after_abort", seen, 0);
      end
      hold_sum = '0;
      hold_cout = 0;
      op(8'h3C, 8'hC4, 1, -1);
      for (int i = 0; i < 24; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         repeat (gap) step();
         op(W'($urandom), W'($urandom), 1'($urandom), (i % 5 == 0) ? int'($urandom_range(0, W - 2)) : -1);
      end
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
